// File: rtl/lsu_bus_bridge_pkg.sv
// Shared types for the LSU-to-memory-bus bridge: bus state encoding, byte-enable type and
// word-alignment helper.
package lsu_bus_bridge_pkg;

  typedef logic [31:0] IntReg;
  typedef logic [3:0]  MemStrb;

  localparam MemStrb STRB_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } BridgeState;

  function automatic IntReg word_align(input IntReg addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/lsu_bus_bridge_post_buffer.sv
// lsu_post_buffer: one-entry posted store buffer, present only when LSU_BRIDGE_POSTED_WRITE_EN
// is defined. Push fills the entry; pop (drain accepted or aborted) empties it.
`ifdef LSU_BRIDGE_POSTED_WRITE_EN
module lsu_post_buffer
  import lsu_bus_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  strb_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  strb_o
);

  logic   full_q, full_d;
  IntReg  addr_q, addr_d;
  IntReg  data_q, data_d;
  MemStrb strb_q, strb_d;

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    strb_d = strb_q;
    if (pop_i) begin
      full_d = 1'b0;
    end
    if (push_i) begin
      full_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
      strb_d = strb_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= STRB_NONE;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign strb_o = strb_q;

endmodule
`endif

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: turns single-cycle LSU reads/writes into req/gnt/rvalid memory transactions,
// stalling the core until done, with bus timeout. LSU_BRIDGE_POSTED_WRITE_EN adds a posted store.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] w_bus_addr,
  input  logic [31:0] w_bus_data,
  input  logic [3:0]  w_bus_strb,
  input  logic        w_bus_valid,
  input  logic [31:0] r_bus_addr,
  input  logic        r_bus_valid,
  output logic [31:0] r_bus_data,
  output logic        stall,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Counter holds the number of cycles already waited; abort on the TIMEOUT_CYCLES-th.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  BridgeState       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  IntReg            addr_q, addr_d;
  IntReg            wdata_q, wdata_d;
  IntReg            rdata_q, rdata_d;
  MemStrb           strb_q, strb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   launch, l_we;
  IntReg  l_addr, l_wdata;
  MemStrb l_strb;
  logic   any_valid, timeout_hit, abort;

  assign any_valid   = w_bus_valid | r_bus_valid;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

`ifdef LSU_BRIDGE_POSTED_WRITE_EN
  logic   drain_q, drain_d;
  logic   buf_full, buf_push, buf_pop;
  IntReg  buf_addr, buf_data;
  MemStrb buf_strb;

  lsu_post_buffer u_post_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (buf_push),
    .addr_i (w_bus_addr),
    .data_i (w_bus_data),
    .strb_i (w_bus_strb),
    .pop_i  (buf_pop),
    .full_o (buf_full),
    .addr_o (buf_addr),
    .data_o (buf_data),
    .strb_o (buf_strb)
  );

  assign buf_push = (state_q == IDLE) && !buf_full && w_bus_valid;
  assign buf_pop  = drain_q && (state_q == REQ) && (mem_gnt || timeout_hit);
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    l_we    = 1'b0;
    l_addr  = r_bus_addr;
    l_wdata = '0;
    l_strb  = STRB_NONE;
    abort   = 1'b0;
    stall   = 1'b0;
`ifdef LSU_BRIDGE_POSTED_WRITE_EN
    drain_d = drain_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef LSU_BRIDGE_POSTED_WRITE_EN
        // A buffered store always drains first; a new store is absorbed with no stall.
        stall = w_bus_valid ? buf_full : r_bus_valid;
        if (buf_full) begin
          launch  = 1'b1;
          l_we    = 1'b1;
          l_addr  = buf_addr;
          l_wdata = buf_data;
          l_strb  = buf_strb;
          drain_d = 1'b1;
        end else if (r_bus_valid && !w_bus_valid) begin
          launch  = 1'b1;
          drain_d = 1'b0;
        end
`else
        stall = any_valid;
        // Write wins when both valids are up; the read is dropped.
        if (w_bus_valid) begin
          launch  = 1'b1;
          l_we    = 1'b1;
          l_addr  = w_bus_addr;
          l_wdata = w_bus_data;
          l_strb  = w_bus_strb;
        end else if (r_bus_valid) begin
          launch = 1'b1;
        end
`endif
      end
      REQ: begin
        stall = 1'b1;
        if (mem_gnt) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = we_q ? DONE : WAIT_R;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef LSU_BRIDGE_POSTED_WRITE_EN
    // During a background drain the core only waits if it is presenting an access.
    if (drain_q && (state_q != IDLE)) begin
      stall = any_valid;
    end
`endif

    if (launch) begin
      state_d = REQ;
      req_d   = 1'b1;
      cnt_d   = '0;
      we_d    = l_we;
      addr_d  = word_align(l_addr);
      wdata_d = l_wdata;
      strb_d  = l_strb;
    end

    if (abort) begin
      state_d = DONE;
      req_d   = 1'b0;
      rdata_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= STRB_NONE;
      cnt_q   <= '0;
`ifdef LSU_BRIDGE_POSTED_WRITE_EN
      drain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
`ifdef LSU_BRIDGE_POSTED_WRITE_EN
      drain_q <= drain_d;
`endif
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_strb   = strb_q;
  assign r_bus_data = rdata_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge (default build): directed cases then randomized accesses, each
// checked against a timing/result model derived from grant and rvalid delays.
module tb_lsu_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] w_bus_addr, w_bus_data, r_bus_addr, r_bus_data;
  logic [3:0]  w_bus_strb, mem_strb;
  logic        w_bus_valid, r_bus_valid, stall, bus_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .w_bus_addr  (w_bus_addr),
    .w_bus_data  (w_bus_data),
    .w_bus_strb  (w_bus_strb),
    .w_bus_valid (w_bus_valid),
    .r_bus_addr  (r_bus_addr),
    .r_bus_valid (r_bus_valid),
    .r_bus_data  (r_bus_data),
    .stall       (stall),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_strb    (mem_strb),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // g = REQ cycles without grant before the grant; v = WAIT_R cycles before rvalid.
  task automatic do_access(input logic wr, input logic both, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input int g, input int v, input logic [31:0] rd);
    int          exp_stall, exp_req, nstall, nreq;
    logic        exp_err, finished;
    logic [31:0] exp_rdata;
    if (g >= TO) begin
      exp_stall = 1 + TO; exp_req = TO; exp_err = 1'b1; exp_rdata = '0;
    end else if (wr) begin
      exp_stall = g + 2; exp_req = g + 1; exp_err = 1'b0; exp_rdata = model_rdata;
    end else if (v >= TO) begin
      exp_stall = g + 2 + TO; exp_req = g + 1; exp_err = 1'b1; exp_rdata = '0;
    end else begin
      exp_stall = g + v + 3; exp_req = g + 1; exp_err = 1'b0; exp_rdata = rd;
    end
    nstall = 0;
    nreq = 0;
    finished = 1'b0;
    @(negedge clk);
    w_bus_addr  = a;
    w_bus_data  = d;
    w_bus_strb  = s;
    r_bus_addr  = both ? ~a : a;
    w_bus_valid = wr;
    r_bus_valid = !wr || both;
    for (int cyc = 0; cyc < 40; cyc++) begin
      mem_gnt    = (cyc == g + 1);
      mem_rvalid = !wr && (cyc == g + v + 2);
      mem_rdata  = mem_rvalid ? rd : $urandom();
      #1;
      if (mem_req) nreq++;
      if (cyc == 1) begin
        check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("req_we", 32'(mem_we), 32'(wr));
        check("req_strb", 32'(mem_strb), wr ? 32'(s) : 32'd0);
        if (wr) check("req_wdata", mem_wdata, d);
      end
      if (!stall) begin
        finished = 1'b1;
        break;
      end
      nstall++;
      @(negedge clk);
    end
    check("done_reached", 32'(finished), 32'd1);
    check("stall_cycles", 32'(nstall), 32'(exp_stall));
    check("req_cycles", 32'(nreq), 32'(exp_req));
    check("done_bus_err", 32'(bus_err), 32'(exp_err));
    check("done_rdata", r_bus_data, exp_rdata);
    model_rdata = exp_rdata;
    // Back in IDLE: stray grant/rvalid must be ignored.
    @(negedge clk);
    w_bus_valid = 1'b0;
    r_bus_valid = 1'b0;
    mem_gnt     = 1'($urandom_range(0, 1));
    mem_rvalid  = 1'($urandom_range(0, 1));
    mem_rdata   = $urandom();
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check("idle_rdata", r_bus_data, model_rdata);
    check("idle_bus_err", 32'(bus_err), 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    w_bus_addr  = '0;
    w_bus_data  = '0;
    w_bus_strb  = '0;
    w_bus_valid = 1'b0;
    r_bus_addr  = '0;
    r_bus_valid = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_strb", 32'(mem_strb), 32'd0);
    check("rst_rdata", r_bus_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b0, 1'b0, 32'h0000_1004, 32'h0, 4'h0, 2, 0, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 32'h0000_0102, 32'h00AB_0000, 4'b0100, 0, 0, 32'h0);

    // Reset while a request is outstanding.
    @(negedge clk);
    r_bus_addr  = 32'h0000_2000;
    r_bus_valid = 1'b1;
    @(negedge clk);
    #1;
    check("rstreq_pre_req", 32'(mem_req), 32'd1);
    rst_n       = 1'b0;
    r_bus_valid = 1'b0;
    #1;
    check("rstreq_req", 32'(mem_req), 32'd0);
    check("rstreq_stall", 32'(stall), 32'd0);
    check("rstreq_rdata", r_bus_data, 32'd0);
    model_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in WAIT_R, then a late rvalid after release.
    @(negedge clk);
    r_bus_addr  = 32'h0000_3008;
    r_bus_valid = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("rstwr_pre_stall", 32'(stall), 32'd1);
    rst_n       = 1'b0;
    r_bus_valid = 1'b0;
    #1;
    check("rstwr_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check("rstwr_rdata", r_bus_data, 32'd0);
    check("rstwr_idle_stall", 32'(stall), 32'd0);
    check("rstwr_bus_err", 32'(bus_err), 32'd0);

    do_access(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 10, 0, 32'h1111_2222);
    do_access(1'b1, 1'b0, 32'h0000_5006, 32'h5555_AAAA, 4'b1100, 10, 0, 32'h0);
    do_access(1'b0, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 0, 0, 32'h7777_8888);
    do_access(1'b0, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 1, 9, 32'h9999_0000);
    do_access(1'b1, 1'b1, 32'h0000_8001, 32'h1234_5678, 4'b0011, 0, 0, 32'h0);
    do_access(1'b0, 1'b0, 32'h0000_9000, 32'h0, 4'h0, 3, 3, 32'hA5A5_5A5A);

    for (int i = 0; i < 40; i++) begin
      logic        rwr, rboth;
      logic [31:0] ra, rdat, rrd;
      logic [3:0]  rs;
      int          rg, rv;
      rwr   = 1'($urandom_range(0, 1));
      rboth = rwr && ($urandom_range(0, 7) == 0);
      ra    = $urandom();
      rdat  = $urandom();
      rrd   = $urandom();
      rs    = 4'($urandom_range(1, 15));
      rg    = int'($urandom_range(0, 5));
      rv    = int'($urandom_range(0, 5));
      do_access(rwr, rboth, ra, rdat, rs, rg, rv, rrd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
